// File: rtl/hazard_pkg.sv
// Shared encodings and widths for the pipeline hazard controller.
package hazard_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        MD_BUSY   = 2'd2
    } hazardState_t;

    // Operand forwarding selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Result-select encoding that marks a load in E
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Load down-counter width; covers LOAD_STALL-1 for LOAD_STALL up to 3
    localparam int unsigned LOAD_CNT_W = 2;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating performance counter with synchronous clear.
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Clear wins over increment; the count holds once it reaches all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// multi-cycle execute handshake, redirect flush and perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_STALL = 1,   // 1..3; >=2 relies on RF write-before-read
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic [1:0]        result_src_e,
    input  logic              pc_src_e,
    input  logic              md_start_e,
    input  logic              md_done,
    input  logic              clr_cnt,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redirect_cnt
);

    hazardState_t          state;
    hazardState_t          stateNext;
    logic [LOAD_CNT_W-1:0] loadCnt;
    logic [LOAD_CNT_W-1:0] loadCntNext;
    logic                  loadUse;

    // Operand A select: M result beats W result; x0 never forwards
    always_comb begin
        forward_a_e = FWD_RF;
        if (reg_write_m && (rs1_e == rd_m) && (rs1_e != '0)) begin
            forward_a_e = FWD_M;
        end else if (reg_write_w && (rs1_e == rd_w) && (rs1_e != '0)) begin
            forward_a_e = FWD_W;
        end
    end

    // Operand B select: same rule as A
    always_comb begin
        forward_b_e = FWD_RF;
        if (reg_write_m && (rs2_e == rd_m) && (rs2_e != '0)) begin
            forward_b_e = FWD_M;
        end else if (reg_write_w && (rs2_e == rd_w) && (rs2_e != '0)) begin
            forward_b_e = FWD_W;
        end
    end

    assign loadUse = (result_src_e == RESULT_SRC_LOAD) && (rd_e != '0) &&
                     ((rs1_d == rd_e) || (rs2_d == rd_e));

    // State and load down-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            loadCnt <= '0;
        end else begin
            state   <= stateNext;
            loadCnt <= loadCntNext;
        end
    end

    // Next state and stall/flush controls; a redirect overrides everything
    always_comb begin
        stateNext   = state;
        loadCntNext = loadCnt;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_m     = 1'b0;

        if (pc_src_e) begin
            flush_d     = 1'b1;
            flush_e     = 1'b1;
            stateNext   = IDLE;
            loadCntNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start_e) begin
                        // A same-cycle result needs no stall at all
                        if (!md_done) begin
                            stall_f   = 1'b1;
                            stall_d   = 1'b1;
                            stall_e   = 1'b1;
                            flush_m   = 1'b1;
                            stateNext = MD_BUSY;
                        end
                    end else if (loadUse) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                        if (LOAD_STALL > 1) begin
                            loadCntNext = LOAD_CNT_W'(LOAD_STALL - 1);
                            stateNext   = LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    stall_f     = 1'b1;
                    stall_d     = 1'b1;
                    flush_e     = 1'b1;
                    loadCntNext = loadCnt - LOAD_CNT_W'(1);
                    if (loadCnt == LOAD_CNT_W'(1)) begin
                        stateNext = IDLE;
                    end
                end
                MD_BUSY: begin
                    if (md_done) begin
                        stateNext = IDLE;
                    end else begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        stall_e = 1'b1;
                        flush_m = 1'b1;
                    end
                end
                default: begin
                    stateNext   = IDLE;
                    loadCntNext = '0;
                end
            endcase
        end
    end

    // Cycles with the front end held
    hazard_perf_cnt #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_f),
        .clr   (clr_cnt),
        .count (stall_cnt)
    );

    // Cycles with a taken redirect in E
    hazard_perf_cnt #(.CNT_W(CNT_W)) uRedirectCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_src_e),
        .clr   (clr_cnt),
        .count (redirect_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the RV32I 5-stage core. It is the successor to the current combinational hazard logic. It adds full A/B operand forwarding, a configurable multi-cycle load-use stall, and a stall/bubble handshake with a multi-cycle execute unit (M-extension mul/div). It also keeps saturating performance counters for stall and redirect cycles. It sits beside the F/D/E/M/W pipeline registers and drives their enable and flush controls.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- LOAD_STALL, 1, load-use stall cycles. Legal range is 1..3; values ≥2 rely on register-file write-before-read.
- CNT_W, 32, performance-counter width.

Ports:
- Clocking and reset (already decided): one clock, `clk`; reset `rst_n`, asynchronous, active-low.
- rs1_d, rs2_d — in, REG_AW: source registers of the instruction in D.
- rs1_e, rs2_e, rd_e — in, REG_AW: source and destination registers of the instruction in E.
- rd_m, rd_w — in, REG_AW: destination registers in M and W.
- reg_write_m, reg_write_w — in, 1: write-enables of the instructions in M and W.
- result_src_e — in, 2: result select of E; 2'b01 means load.
- pc_src_e — in, 1: taken branch/jump resolved in E.
- md_start_e — in, 1: a multi-cycle op is in E this cycle.
- md_done — in, 1: the mul/div result is valid this cycle.
- clr_cnt — in, 1: synchronous clear of both counters.
- stall_f, stall_d, stall_e — out, 1: hold the F, D and E pipeline registers.
- flush_d, flush_e, flush_m — out, 1: insert a bubble into D, E or M.
- forward_a_e, forward_b_e — out, 2: operand select. 00 = register file, 01 = W result, 10 = M ALU result.
- stall_cnt, redirect_cnt — out, CNT_W: performance counters.

## Operation
- Forwarding is combinational and is computed identically for A (rs1_e) and B (rs2_e):
  - If rs == rd_m, reg_write_m = 1 and rs ≠ 0, select 10.
  - Else if rs == rd_w, reg_write_w = 1 and rs ≠ 0, select 01.
  - Else select 00.
- Load-use condition: result_src_e == 01, rd_e ≠ 0, and (rs1_d == rd_e or rs2_d == rd_e).
- State machine, held in the state register, with states IDLE, LOAD_WAIT and MD_BUSY:
  - IDLE, load-use true: assert stall_f, stall_d and flush_e. If LOAD_STALL > 1, load the down-counter with LOAD_STALL-1 and go to LOAD_WAIT.
  - LOAD_WAIT: assert stall_f, stall_d and flush_e; decrement the counter. At the edge where the counter equals 1, go to IDLE.
  - IDLE, md_start_e = 1 and md_done = 0: go to MD_BUSY. The same cycle asserts stall_f, stall_d, stall_e and flush_m.
  - MD_BUSY: assert stall_f, stall_d, stall_e and flush_m while md_done = 0. In the cycle md_done = 1, release all stalls and go to IDLE.
  - IDLE, md_start_e = 1 and md_done = 1 (single-cycle result): no stall.
- Redirect: pc_src_e = 1 asserts flush_d and flush_e and forces stall_f and stall_d low.
  - If the state is LOAD_WAIT, return to IDLE.
- Priority: pc_src_e > multi-cycle op > load-use.
  - pc_src_e and md_start_e are mutually exclusive by construction.
  - A bench may assert both; the required result is redirect behaviour with the op dropped and the state going to IDLE.
- Counters:
  - stall_cnt increments every cycle stall_f = 1.
  - redirect_cnt increments every cycle pc_src_e = 1.
  - Both saturate at all-ones.
  - clr_cnt has priority over increment and clears the counter to 0 at the next edge.

## Timing
- Stall and flush latency:
  - Forwarding selects are combinational, with zero latency.
  - All stall and flush outputs are combinational from the current state and current inputs; there is no registered output delay.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the load counter to 0.
  - stall_cnt = 0 and redirect_cnt = 0.
  - Stall and flush outputs follow the IDLE equations.
- Reset asserted mid-operation (LOAD_WAIT or MD_BUSY) aborts immediately; the next cycle after release is IDLE.
- Load-use stall: exactly LOAD_STALL consecutive cycles of stall_f and stall_d.
- Multi-cycle op: the stall length equals the number of cycles until md_done, inclusive of the start cycle and exclusive of the done cycle.
- Counter saturation: at all-ones, further increments hold the value.

## Structure
- hazard_pkg holds:
  - state encodings (IDLE, LOAD_WAIT, MD_BUSY);
  - FWD_RF, FWD_W, FWD_M;
  - RESULT_SRC_LOAD = 2'b01.
- Sub-module hazard_perf_cnt: a CNT_W saturating counter with inc and clr inputs, instantiated twice.
- The forwarding mux select is duplicated in-line for A and B (no sub-module).

## Test plan
- Forwarding:
  - rs1_e = 5, rd_m = 5, reg_write_m = 1, rd_w = 5, reg_write_w = 1 → forward_a_e = 10.
  - Then set rs1_e = 0 → forward_a_e = 00.
  - rs2_e = 7, rd_w = 7, reg_write_w = 1 → forward_b_e = 01.
- Load-use with LOAD_STALL = 3: load with rd_e = 3 in E, rs2_d = 3 → stall_f, stall_d and flush_e high for exactly 3 cycles; stall_cnt = 3.
- Multi-cycle op: md_start_e pulse, md_done 4 cycles later → stall_e and flush_m high for 4 cycles, low on the md_done cycle.
- Redirect during LOAD_WAIT (LOAD_STALL = 3, pc_src_e in the 2nd stall cycle) → flush_d and flush_e = 1, stall_f = 0, IDLE next cycle, redirect_cnt = 1.
- Reset in MD_BUSY: rst_n low for 1 cycle → state IDLE, counters 0, stalls low afterwards with md_done never asserted.
- Counter saturation with CNT_W = 4: 20 stall cycles → stall_cnt = 15; clr_cnt together with a stall → stall_cnt = 0.
